// File: rtl/median_scan_ctrl_if.sv
// Read-port and window-handshake bundle between median_scan_ctrl and the
// pixel memory / median core.
interface median_scan_ctrl_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DIM_WIDTH  = 10
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [3:0]            tap_idx;
    logic                  tap_zero;
    logic                  win_valid;
    logic                  core_ready;
    logic [DIM_WIDTH-1:0]  pix_x;
    logic [DIM_WIDTH-1:0]  pix_y;

    modport master (
        output rd_en, rd_addr, tap_idx, tap_zero, win_valid, pix_x, pix_y,
        input  core_ready
    );

    modport slave (
        input  rd_en, rd_addr, tap_idx, tap_zero, win_valid, pix_x, pix_y,
        output core_ready
    );
endinterface

// File: rtl/median_scan_ctrl.sv
// Raster frame-scan sequencer issuing nine 3x3-window reads per output pixel.
// Optional macro ZERO_PAD_EN: out-of-frame taps become zero taps instead of clamped reads.
module median_scan_ctrl #(
    parameter int ADDR_WIDTH = 18,
    parameter int DIM_WIDTH  = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    median_scan_ctrl_if.master    bus,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DIM_WIDTH-1:0]  D_ZERO = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0]  D_ONE  = DIM_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ZERO = {ADDR_WIDTH{1'b0}};

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_k, w_k_nxt;
    logic [DIM_WIDTH-1:0]  r_pix_x, w_pix_x_nxt;
    logic [DIM_WIDTH-1:0]  r_pix_y, w_pix_y_nxt;
    logic [DIM_WIDTH-1:0]  r_width, w_width_nxt;
    logic [DIM_WIDTH-1:0]  r_height, w_height_nxt;
    logic [ADDR_WIDTH-1:0] r_row_prev, w_row_prev_nxt;
    logic [ADDR_WIDTH-1:0] r_row_cur, w_row_cur_nxt;
    logic [ADDR_WIDTH-1:0] r_row_next, w_row_next_nxt;

    logic                  r_rd_en, w_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr;
    logic [3:0]            r_tap_idx, w_tap_idx;
    logic                  r_tap_zero, w_tap_zero;
    logic                  r_win_valid, w_win_valid;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;

    logic [1:0]            w_dx, w_dy;
    logic [DIM_WIDTH-1:0]  w_col;
    logic [ADDR_WIDTH-1:0] w_base;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and counter / row-base update logic
    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_pix_x_nxt    = r_pix_x;
        w_pix_y_nxt    = r_pix_y;
        w_width_nxt    = r_width;
        w_height_nxt   = r_height;
        w_row_prev_nxt = r_row_prev;
        w_row_cur_nxt  = r_row_cur;
        w_row_next_nxt = r_row_next;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_width_nxt  = width;
                    w_height_nxt = height;
                    if ((width == D_ZERO) || (height == D_ZERO)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pix_x_nxt    = D_ZERO;
                        w_pix_y_nxt    = D_ZERO;
                        w_k_nxt        = 4'd0;
                        w_row_prev_nxt = A_ZERO;
                        w_row_cur_nxt  = A_ZERO;
                        w_row_next_nxt = (height > D_ONE) ? ADDR_WIDTH'(width) : A_ZERO;
                        w_state_nxt    = S_FETCH;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_k == 4'd8) begin
                    w_state_nxt = S_LAST;
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end
            S_LAST: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.core_ready) begin
                    w_k_nxt = 4'd0;
                    if (r_pix_x != (r_width - D_ONE)) begin
                        w_pix_x_nxt = r_pix_x + D_ONE;
                        w_state_nxt = S_FETCH;
                    end else if (r_pix_y != (r_height - D_ONE)) begin
                        w_pix_x_nxt    = D_ZERO;
                        w_pix_y_nxt    = r_pix_y + D_ONE;
                        w_row_prev_nxt = r_row_cur;
                        w_row_cur_nxt  = r_row_next;
                        // Once the new row is the bottom row, row_next stays put to clamp dy=2.
                        if ((r_pix_y + D_ONE) != (r_height - D_ONE)) begin
                            w_row_next_nxt = r_row_next + ADDR_WIDTH'(r_width);
                        end else begin
                            w_row_next_nxt = r_row_next;
                        end
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from next-cycle values so every output leaves a flop
    always_comb begin
        case (w_k_nxt)
            4'd0:    {w_dy, w_dx} = {2'd0, 2'd0};
            4'd1:    {w_dy, w_dx} = {2'd0, 2'd1};
            4'd2:    {w_dy, w_dx} = {2'd0, 2'd2};
            4'd3:    {w_dy, w_dx} = {2'd1, 2'd0};
            4'd4:    {w_dy, w_dx} = {2'd1, 2'd1};
            4'd5:    {w_dy, w_dx} = {2'd1, 2'd2};
            4'd6:    {w_dy, w_dx} = {2'd2, 2'd0};
            4'd7:    {w_dy, w_dx} = {2'd2, 2'd1};
            4'd8:    {w_dy, w_dx} = {2'd2, 2'd2};
            default: {w_dy, w_dx} = {2'd1, 2'd1};
        endcase
        case (w_dx)
            2'd0:    w_col = (w_pix_x_nxt == D_ZERO) ? D_ZERO : (w_pix_x_nxt - D_ONE);
            2'd2:    w_col = (w_pix_x_nxt == (w_width_nxt - D_ONE)) ? w_pix_x_nxt : (w_pix_x_nxt + D_ONE);
            default: w_col = w_pix_x_nxt;
        endcase
        case (w_dy)
            2'd0:    w_base = w_row_prev_nxt;
            2'd2:    w_base = w_row_next_nxt;
            default: w_base = w_row_cur_nxt;
        endcase
        w_rd_addr = w_base + ADDR_WIDTH'(w_col);
        w_tap_idx = w_k_nxt;
`ifdef ZERO_PAD_EN
        if (w_state_nxt == S_FETCH) begin
            w_tap_zero = ((w_dx == 2'd0) && (w_pix_x_nxt == D_ZERO))
                      || ((w_dx == 2'd2) && (w_pix_x_nxt == (w_width_nxt - D_ONE)))
                      || ((w_dy == 2'd0) && (w_pix_y_nxt == D_ZERO))
                      || ((w_dy == 2'd2) && (w_pix_y_nxt == (w_height_nxt - D_ONE)));
            w_rd_en    = ~w_tap_zero;
        end else begin
            w_tap_zero = 1'b0;
            w_rd_en    = 1'b0;
        end
`else
        w_rd_en    = (w_state_nxt == S_FETCH);
        w_tap_zero = 1'b0;
`endif
        w_win_valid = (w_state_nxt == S_WAIT);
        w_busy      = (w_state_nxt != S_IDLE);
        w_done      = (w_state_nxt == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_k         <= 4'd0;
            r_pix_x     <= D_ZERO;
            r_pix_y     <= D_ZERO;
            r_width     <= D_ZERO;
            r_height    <= D_ZERO;
            r_row_prev  <= A_ZERO;
            r_row_cur   <= A_ZERO;
            r_row_next  <= A_ZERO;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= A_ZERO;
            r_tap_idx   <= 4'd0;
            r_tap_zero  <= 1'b0;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_k         <= w_k_nxt;
            r_pix_x     <= w_pix_x_nxt;
            r_pix_y     <= w_pix_y_nxt;
            r_width     <= w_width_nxt;
            r_height    <= w_height_nxt;
            r_row_prev  <= w_row_prev_nxt;
            r_row_cur   <= w_row_cur_nxt;
            r_row_next  <= w_row_next_nxt;
            r_rd_en     <= w_rd_en;
            r_rd_addr   <= w_rd_addr;
            r_tap_idx   <= w_tap_idx;
            r_tap_zero  <= w_tap_zero;
            r_win_valid <= w_win_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.tap_idx   = r_tap_idx;
    assign bus.tap_zero  = r_tap_zero;
    assign bus.win_valid = r_win_valid;
    assign bus.pix_x     = r_pix_x;
    assign bus.pix_y     = r_pix_y;
    assign busy          = r_busy;
    assign done          = r_done;
endmodule

// File: tb/tb_median_scan_ctrl.sv
// Self-checking bench for median_scan_ctrl: randomized frames scored against a
// clamp/zero-pad window model computed directly from pixel coordinates.
module tb_median_scan_ctrl;
    localparam int AW = 18;
    localparam int DW = 10;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          abort;
    logic [DW-1:0] width;
    logic [DW-1:0] height;
    logic          busy;
    logic          done;

    median_scan_ctrl_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();

    median_scan_ctrl #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .abort  (abort),
        .width  (width),
        .height (height),
        .bus    (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_addr [4096];
    int n_obs;
    int busy_cycles;
    int stall_seen;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected address of tap k for pixel (x,y) under replicate-clamp
    function automatic int model_addr(input int w, input int h, input int x, input int y, input int k);
        int xx;
        int yy;
        xx = x + (k % 3) - 1;
        yy = y + (k / 3) - 1;
        if (xx < 0) xx = 0;
        if (xx > w - 1) xx = w - 1;
        if (yy < 0) yy = 0;
        if (yy > h - 1) yy = h - 1;
        return yy * w + xx;
    endfunction

    function automatic bit model_zero(input int w, input int h, input int x, input int y, input int k);
        int xx;
        int yy;
        xx = x + (k % 3) - 1;
        yy = y + (k / 3) - 1;
`ifdef ZERO_PAD_EN
        return (xx < 0) || (xx >= w) || (yy < 0) || (yy >= h);
`else
        return 1'b0 && (xx < 0) && (yy < 0);
`endif
    endfunction

    // mode 0: core_ready high; 1: random ready; 2: random ready plus start/width/height noise while busy
    task automatic run_frame(input int w, input int h, input int mode, input int sx, input int sy, input int slen);
        int  exp_a[$];
        int  exp_t[$];
        bit  exp_z[$];
        int  px[$];
        int  py[$];
        int  a;
        int  t;
        bit  z;
        bit  rdy;
        bit  finished;
        int  stall_left;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                px.push_back(x);
                py.push_back(y);
                for (int k = 0; k < 9; k++) begin
                    exp_a.push_back(model_addr(w, h, x, y, k));
                    exp_t.push_back(k);
                    exp_z.push_back(model_zero(w, h, x, y, k));
                end
            end
        end
        start  = 1'b1;
        width  = DW'(w);
        height = DW'(h);
        bus.core_ready = 1'b1;
        tick();
        start = 1'b0;
        n_obs = 0;
        busy_cycles = 0;
        stall_seen = 0;
        stall_left = slen;
        finished = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            if (bus.rd_en || bus.tap_zero) begin
                if (exp_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_read: got addr %0d, required no read", bus.rd_addr);
                end else begin
                    a = exp_a.pop_front();
                    t = exp_t.pop_front();
                    z = exp_z.pop_front();
                    n_cmp++;
                    if (bus.tap_idx !== 4'(t)) begin
                        n_bad++;
                        $display("FAIL tap_idx: got %0d, required %0d", bus.tap_idx, t);
                    end
                    n_cmp++;
                    if ({bus.rd_en, bus.tap_zero} !== {~z, z}) begin
                        n_bad++;
                        $display("FAIL rd_en/tap_zero: got %b%b, required %b%b", bus.rd_en, bus.tap_zero, ~z, z);
                    end
                    if (!z) begin
                        n_cmp++;
                        if (bus.rd_addr !== AW'(a)) begin
                            n_bad++;
                            $display("FAIL rd_addr: (%0dx%0d) tap %0d got %0d, required %0d", w, h, t, bus.rd_addr, a);
                        end
                    end
                    if (n_obs < 4096) obs_addr[n_obs] = int'(bus.rd_addr);
                    n_obs++;
                end
            end
            if (busy && !done) busy_cycles++;
            if (bus.win_valid) begin
                n_cmp++;
                if (bus.rd_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd_during_wait: got rd_en %b, required 0", bus.rd_en);
                end
                if (px.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_window: got (%0d,%0d), required none", bus.pix_x, bus.pix_y);
                    rdy = 1'b1;
                end else begin
                    n_cmp++;
                    if ({bus.pix_x, bus.pix_y} !== {DW'(px[0]), DW'(py[0])}) begin
                        n_bad++;
                        $display("FAIL pix_xy: got (%0d,%0d), required (%0d,%0d)", bus.pix_x, bus.pix_y, px[0], py[0]);
                    end
                    if (slen > 0 && stall_left > 0 && px[0] == sx && py[0] == sy) begin
                        rdy = 1'b0;
                        stall_left--;
                        stall_seen++;
                    end else if (mode == 0) begin
                        rdy = 1'b1;
                    end else begin
                        rdy = ($urandom % 10) >= 3;
                    end
                    if (rdy) begin
                        void'(px.pop_front());
                        void'(py.pop_front());
                    end
                end
            end else begin
                rdy = (mode == 0) ? 1'b1 : 1'($urandom % 2);
            end
            bus.core_ready = rdy;
            if (mode == 2) begin
                start  = 1'($urandom % 2);
                width  = DW'($urandom);
                height = DW'($urandom);
            end
            if (done) finished = 1'b1;
            tick();
        end
        start = 1'b0;
        bus.core_ready = 1'b1;
        n_cmp++;
        if (!finished) begin
            n_bad++;
            $display("FAIL done_timeout: got no done, required done for %0dx%0d", w, h);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL after_done: got busy/done %b%b, required 00", busy, done);
        end
        n_cmp++;
        if (exp_a.size() != 0 || px.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d reads %0d windows missing, required 0", exp_a.size(), px.size());
        end
        if (slen > 0) begin
            n_cmp++;
            if (stall_seen != slen) begin
                n_bad++;
                $display("FAIL stall_len: got %0d, required %0d", stall_seen, slen);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; abort = 1'b0; width = '0; height = '0; bus.core_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, done, bus.rd_en, bus.win_valid, bus.tap_zero, bus.tap_idx, bus.rd_addr, bus.pix_x, bus.pix_y} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy %b done %b rd_en %b addr %0d", busy, done, bus.rd_en, bus.rd_addr);
        end
        RST = 1'b0;
        start = 1'b1; width = DW'(3); height = DW'(3);
        tick();
        start = 1'b0;
        repeat (13) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_cmp++;
        if ({busy, done, bus.rd_en, bus.win_valid, bus.pix_x, bus.pix_y} !== '0) begin
            n_bad++;
            $display("FAIL midframe_reset: got busy %b rd_en %b pix (%0d,%0d), required 0", busy, bus.rd_en, bus.pix_x, bus.pix_y);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_no_done: got busy/done %b%b, required 00", busy, done);
            end
            tick();
        end
    endtask

    task automatic test_frame_3x3();
        int exp00 [9] = '{0, 0, 1, 0, 0, 1, 3, 3, 4};
        run_frame(3, 3, 0, 0, 0, 0);
        n_cmp++;
        if (busy_cycles != 1 + 9 * 11 - 1) begin
            n_bad++;
            $display("FAIL cycles_3x3: got %0d, required %0d", busy_cycles, 9 * 11);
        end
`ifndef ZERO_PAD_EN
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (obs_addr[k] != exp00[k]) begin
                n_bad++;
                $display("FAIL addr_00 k%0d: got %0d, required %0d", k, obs_addr[k], exp00[k]);
            end
            n_cmp++;
            if (obs_addr[36 + k] != k) begin
                n_bad++;
                $display("FAIL addr_11 k%0d: got %0d, required %0d", k, obs_addr[36 + k], k);
            end
        end
`endif
    endtask

    task automatic test_tall_rows();
        run_frame(100, 4, 0, 0, 0, 0);
`ifndef ZERO_PAD_EN
        n_cmp++;
        if (obs_addr[(3 * 100 + 5) * 9 + 8] != 306) begin
            n_bad++;
            $display("FAIL addr_5_3_k8: got %0d, required 306", obs_addr[(3 * 100 + 5) * 9 + 8]);
        end
`endif
    endtask

    task automatic test_zero_dim();
        int dims [2][2] = '{'{0, 5}, '{4, 0}};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; width = DW'(dims[i][0]); height = DW'(dims[i][1]);
            tick();
            start = 1'b0;
            n_cmp++;
            if ({busy, done, bus.rd_en} !== 3'b110) begin
                n_bad++;
                $display("FAIL zero_dim_done: got busy/done/rd_en %b%b%b, required 110", busy, done, bus.rd_en);
            end
            tick();
            n_cmp++;
            if ({busy, done, bus.rd_en} !== 3'b000) begin
                n_bad++;
                $display("FAIL zero_dim_idle: got busy/done/rd_en %b%b%b, required 000", busy, done, bus.rd_en);
            end
        end
    endtask

    task automatic test_stall();
        run_frame(4, 2, 0, 2, 0, 20);
    endtask

    task automatic test_abort();
        bit found;
        start = 1'b1; width = DW'(5); height = DW'(4);
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.rd_en && bus.tap_idx == 4'd4) found = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_tap4_timeout: got no k=4 read, required one");
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({busy, done, bus.rd_en, bus.win_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL abort_fetch: got busy/done/rd_en/wv %b%b%b%b, required 0000", busy, done, bus.rd_en, bus.win_valid);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_bad++;
                $display("FAIL abort_no_done: got busy/done %b%b, required 00", busy, done);
            end
            tick();
        end
        run_frame(5, 4, 0, 0, 0, 0);
        // abort must win over a completing handshake on the last pixel
        start = 1'b1; width = DW'(1); height = DW'(1); bus.core_ready = 1'b0;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.win_valid) found = 1'b1;
            else tick();
        end
        abort = 1'b1;
        bus.core_ready = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({found, busy, done} !== 3'b100) begin
            n_bad++;
            $display("FAIL abort_wait: got found/busy/done %b%b%b, required 100", found, busy, done);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 7), $urandom_range(1, 6), 1, 0, 0, 0);
        end
        run_frame(1, 1, 0, 0, 0, 0);
        run_frame($urandom_range(2, 6), $urandom_range(2, 5), 2, 0, 0, 0);
        run_frame(1, $urandom_range(2, 5), 2, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_frame_3x3();
        test_zero_dim();
        test_stall();
        test_tall_rows();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
